// File: rtl/crumb_pkg.sv
// ----------------------------------------------------------------------------
// crumb_pkg
// Shared constants for the cookie display frame reader.
//   GRID_W_DEF / GRID_H_DEF : default grid geometry (cells per row, rows)
//   ST_*                    : reader FSM state encodings
//   idx_w / cnt_w / pop_w   : derived widths for row index, bit counter and
//                             live-cell count
// ----------------------------------------------------------------------------
package crumb_pkg;

   localparam int GRID_W_DEF = 16;
   localparam int GRID_H_DEF = 16;

   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_LATCH   = 3'd1;
   localparam logic [STATE_W-1:0] ST_SHIFT   = 3'd2;
   localparam logic [STATE_W-1:0] ST_PRESENT = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

   // Row index width.
   function automatic int idx_w(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

   // Bit counter must be able to hold GRID_W itself (row complete).
   function automatic int cnt_w(input int cols);
      return $clog2(cols + 1);
   endfunction

   // Live count covers 0..GRID_W*GRID_H inclusive.
   function automatic int pop_w(input int cols, input int rows);
      return $clog2(cols * rows) + 1;
   endfunction

endpackage

// File: rtl/crumb_row_shifter.sv
// ----------------------------------------------------------------------------
// crumb_row_shifter
// Serial-in / parallel-out row register. Each sampled bit lands in column
// GRID_W-1-bitcnt, so the first bit of a row fills the top column.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the load position at column GRID_W-1
//   sample    : capture bit_in on this edge
//   bit_in    : serial data from the display chain
//   row_data  : assembled row (held while sample is low)
//   row_full  : this edge captures the last bit of the row
// ----------------------------------------------------------------------------
module crumb_row_shifter
   import crumb_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              sample,
   input  logic              bit_in,
   output logic [GRID_W-1:0] row_data,
   output logic              row_full
);

   localparam int CNT_W = cnt_w(GRID_W);
   localparam int POS_W = $clog2(GRID_W);

   logic [CNT_W-1:0] bitcnt;
   logic [POS_W-1:0] pos;

   // Column the next sampled bit is written to.
   assign pos      = POS_W'(GRID_W - 1) - bitcnt[POS_W-1:0];
   assign row_full = sample && (bitcnt == CNT_W'(GRID_W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitcnt   <= '0;
         row_data <= '0;
      end else if (clear) begin
         bitcnt <= '0;
      end else if (sample && (bitcnt < CNT_W'(GRID_W))) begin
         row_data[pos] <= bit_in;
         bitcnt        <= bitcnt + 1'b1;
      end
   end

endmodule

// File: rtl/crumb_frame_reader.sv
// ----------------------------------------------------------------------------
// crumb_frame_reader
// Reads one frame out of the cookie grid display chain: pulses display so the
// grid latches its cells, shifts the chain out one bit per cycle and presents
// each GRID_W-bit row downstream, top row first.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle frame request (honoured only in IDLE)
//   busy            : frame in progress (LATCH..DONE)
//   display         : one-cycle latch pulse to the grid
//   shift_en        : advance the grid chain by one bit
//   display_bit_in  : serial bit from the grid chain
//   row_data/row_idx/row_valid/row_ready : row output handshake
//   frame_done      : one-cycle pulse after the last row is accepted
//   live_count      : number of ones in the frame
// Build option: CRUMB_READER_POPCOUNT_EN enables the live_count counter;
// without it live_count is tied to zero.
//
// Handshake: a row transfers on any rising edge where row_valid && row_ready.
// row_valid never drops and row_data/row_idx never change until that
// transfer; row_ready with row_valid low is ignored.
// ----------------------------------------------------------------------------
module crumb_frame_reader
   import crumb_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   output logic                               busy,
   output logic                               display,
   output logic                               shift_en,
   input  logic                               display_bit_in,
   output logic [GRID_W-1:0]                  row_data,
   output logic [idx_w(GRID_H)-1:0]           row_idx,
   output logic                               row_valid,
   input  logic                               row_ready,
   output logic                               frame_done,
   output logic [pop_w(GRID_W, GRID_H)-1:0]   live_count
);

   localparam int IDX_W = idx_w(GRID_H);
   localparam int POP_W = pop_w(GRID_W, GRID_H);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_next;
   logic               row_full;
   logic               transfer;
   logic               row_clear;

   // Outputs are pure state decodes, so reset values follow directly.
   assign busy       = (state != ST_IDLE);
   assign display    = (state == ST_LATCH);
   assign shift_en   = (state == ST_SHIFT);
   assign row_valid  = (state == ST_PRESENT);
   assign frame_done = (state == ST_DONE);

   assign transfer  = row_valid && row_ready;
   assign row_clear = display || transfer;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (start) state_next = ST_LATCH;
         ST_LATCH:   state_next = ST_SHIFT;
         // Leave SHIFT on the edge that captures the last bit so shift_en
         // is already low in the first PRESENT cycle.
         ST_SHIFT:   if (row_full) state_next = ST_PRESENT;
         ST_PRESENT: if (row_ready) state_next = (row_idx == '0) ? ST_DONE : ST_SHIFT;
         ST_DONE:    state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         row_idx <= '0;
      end else begin
         state <= state_next;
         if (display) begin
            row_idx <= IDX_W'(GRID_H - 1);
         end else if (transfer && (row_idx != '0)) begin
            row_idx <= row_idx - 1'b1;
         end
      end
   end

   crumb_row_shifter #(
      .GRID_W (GRID_W)
   ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .clear    (row_clear),
      .sample   (shift_en),
      .bit_in   (display_bit_in),
      .row_data (row_data),
      .row_full (row_full)
   );

`ifdef CRUMB_READER_POPCOUNT_EN
   // Cleared at latch time; holds its final value from DONE until the next
   // frame's LATCH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live_count <= '0;
      end else if (display) begin
         live_count <= '0;
      end else if (shift_en && display_bit_in) begin
         live_count <= live_count + 1'b1;
      end
   end
`else
   assign live_count = POP_W'(0);
`endif

endmodule

// File: tb/tb_crumb_frame_reader.sv
// ----------------------------------------------------------------------------
// tb_crumb_frame_reader
// Directed-plus-random bench for crumb_frame_reader. A behavioural grid holds
// 256 cells (cell k = row k/16, column k%16) and serves them out as a latched
// chain, highest cell first. Expected rows are derived from the cell array.
// Honours CRUMB_READER_POPCOUNT_EN for the live_count expectations.
// ----------------------------------------------------------------------------
module tb_crumb_frame_reader;

   localparam int W = 16;
   localparam int H = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic        display;
   logic        shift_en;
   logic        display_bit_in;
   logic [15:0] row_data;
   logic [3:0]  row_idx;
   logic        row_valid;
   logic        row_ready;
   logic        frame_done;
   logic [8:0]  live_count;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   crumb_frame_reader dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .busy           (busy),
      .display        (display),
      .shift_en       (shift_en),
      .display_bit_in (display_bit_in),
      .row_data       (row_data),
      .row_idx        (row_idx),
      .row_valid      (row_valid),
      .row_ready      (row_ready),
      .frame_done     (frame_done),
      .live_count     (live_count)
   );

   // ---------------- grid model ----------------
   logic [255:0] cells;
   logic [255:0] latched = '0;
   logic [7:0]   pos = 8'd0;

   always @(posedge clk) begin
      if (display) begin
         latched <= cells;
         pos     <= 8'd255;
      end else if (shift_en) begin
         pos <= pos - 8'd1;
      end
   end

   assign display_bit_in = latched[pos];

   // ---------------- scoreboard ----------------
   logic [19:0] exp_q[$];
   int          exp_pop;
   int          total = 0;
   int          bad = 0;

   int          rows_seen;
   int          done_cnt;
   int          done_at;
   int          disp_cnt;
   logic [15:0] row0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic int exp_live(input int pop);
`ifdef CRUMB_READER_POPCOUNT_EN
      return pop;
`else
      return 0 * pop;
`endif
   endfunction

   task automatic load_expect();
      logic [15:0] rowv;
      exp_q.delete();
      exp_pop = 0;
      for (int r = H - 1; r >= 0; r--) begin
         for (int c = 0; c < W; c++) rowv[c] = cells[r * W + c];
         exp_q.push_back({4'(r), rowv});
      end
      for (int k = 0; k < 256; k++) exp_pop += int'(cells[k]);
   endtask

   task automatic random_cells();
      for (int i = 0; i < 8; i++) cells[i * 32 +: 32] = $urandom();
   endtask

   task automatic check_idle(input string pfx);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_display"}, display, 0);
      chk({pfx, "_shift_en"}, shift_en, 0);
      chk({pfx, "_row_valid"}, row_valid, 0);
      chk({pfx, "_frame_done"}, frame_done, 0);
      chk({pfx, "_row_data"}, row_data, 0);
      chk({pfx, "_row_idx"}, row_idx, 0);
      chk({pfx, "_live_count"}, live_count, 0);
   endtask

   // ---------------- driver ----------------
   // Runs one frame. Iteration n observes the DUT after the n-th edge
   // following the start request.
   task automatic run_frame(input bit rand_ready, input int stall_row, input int stall_len,
                            input int restart_at, input int abort_row, input bit start_at_done);
      int stall_left;
      int abort_cnt;
      stall_left = stall_len;
      abort_cnt  = 0;
      rows_seen  = 0;
      done_cnt   = 0;
      done_at    = -1;
      disp_cnt   = 0;
      row0       = 16'h0;
      load_expect();
      @(negedge clk);
      start     = 1'b1;
      row_ready = 1'b1;
      for (int n = 1; n <= 3000; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (display) disp_cnt++;
         if (done_at >= 0) chk("busy_after_done", busy, 0);
         if (frame_done) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
            chk("live_count_done", live_count, exp_live(exp_pop));
            if (start_at_done) start = 1'b1;
         end
         if (n == restart_at) start = 1'b1;

         if (row_valid && (stall_left > 0) && (int'(row_idx) == stall_row)) begin
            row_ready = 1'b0;
            stall_left--;
         end else if (rand_ready) begin
            row_ready = 1'($urandom_range(0, 1));
         end else begin
            row_ready = 1'b1;
         end

         if (row_valid) begin
            chk("shift_en_in_present", shift_en, 0);
            if (exp_q.size() == 0) begin
               chk("rows_overflow", rows_seen + 1, H);
            end else begin
               chk("row_idx", row_idx, exp_q[0][19:16]);
               chk("row_data", row_data, exp_q[0][15:0]);
               if (row_ready) begin
                  void'(exp_q.pop_front());
                  rows_seen++;
                  if (row_idx == 4'd0) row0 = row_data;
               end
            end
         end

         if ((abort_row >= 0) && shift_en && (int'(row_idx) == abort_row)) begin
            abort_cnt++;
            if (abort_cnt == 5) begin
               rst = 1'b1;
               @(negedge clk);
               check_idle("abort");
               rst = 1'b0;
               break;
            end
         end
         if ((done_at >= 0) && (n >= done_at + 6)) break;
      end
      if (abort_row < 0) begin
         chk("frame_done_count", done_cnt, 1);
         chk("rows_seen", rows_seen, H);
         chk("display_count", disp_cnt, 1);
         chk("live_count_hold", live_count, exp_live(exp_pop));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      row_ready = 1'b0;
      cells     = '0;

      // Reset held, then idle with start low.
      repeat (3) begin
         @(negedge clk);
         check_idle("reset");
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_idle("idle");
      end

      // Known pattern: cell k = (k % 3 == 0), ready always high.
      for (int k = 0; k < 256; k++) cells[k] = (k % 3 == 0);
      run_frame(1'b0, -1, 0, -1, -1, 1'b0);
      chk("done_cycle", done_at, 274);
      chk("row0_pattern", row0, 16'h9249);
      chk("live_pattern", live_count, exp_live(86));

      // Backpressure: row 7 stalled for 20 cycles.
      random_cells();
      run_frame(1'b0, 7, 20, -1, -1, 1'b0);
      chk("done_cycle_stall", done_at, 294);

      // Start while busy is ignored.
      random_cells();
      run_frame(1'b0, -1, 0, 50, -1, 1'b0);
      chk("done_cycle_restart", done_at, 274);

      // Reset during row 12 shifting, then a clean frame with random ready.
      random_cells();
      run_frame(1'b0, -1, 0, -1, 12, 1'b0);
      done_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (frame_done || busy) done_cnt++;
      end
      chk("no_activity_after_abort", done_cnt, 0);
      random_cells();
      run_frame(1'b1, -1, 0, -1, -1, 1'b0);

      // All-ones grid, with a start pulse in the DONE cycle.
      cells = '1;
      run_frame(1'b0, -1, 0, -1, -1, 1'b1);
      chk("row0_ones", row0, 16'hFFFF);
      chk("live_ones", live_count, exp_live(256));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
